// File: rtl/uart_tx_switch_pkg.sv
// Shared types and defaults for the glitch-free UART TX source selector.
`ifndef UART_BAUD_PERIOD
`define UART_BAUD_PERIOD 16
`endif

package uart_tx_switch_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } sw_state_e;

    localparam int unsigned IDLE_BITS_DEFAULT   = 11;
    localparam int unsigned BAUD_PERIOD_DEFAULT = `UART_BAUD_PERIOD;

    // Select width for n sources, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/uart_tx_switch_line_idle_timer.sv
// Saturating quiet-window counter; done_c flags the cycle that completes the window.
module line_idle_timer #(
    parameter int unsigned WINDOW = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic done_c
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);

    logic [CNT_W-1:0] count;

    // Fires combinationally on the quiet cycle that brings the count to WINDOW.
    assign done_c = enable && !clear && (count >= CNT_W'(WINDOW - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(WINDOW))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_switch.sv
// Glitch-free TX source selector: switches only after current and requested lines stay idle.
module uart_tx_switch
    import uart_tx_switch_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned BAUD_PERIOD = BAUD_PERIOD_DEFAULT,
    parameter int unsigned IDLE_BITS   = IDLE_BITS_DEFAULT,
    parameter int unsigned RESET_SEL   = 0,
    parameter int unsigned SEL_W       = sel_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] tx_in,
    input  logic [SEL_W-1:0]   sel_req,
    input  logic               force_switch,
    output logic               TXD,
    output logic [SEL_W-1:0]   active_sel,
    output logic               switch_pending,
    output logic               switch_done
);

    localparam int unsigned WINDOW = IDLE_BITS * BAUD_PERIOD;

    sw_state_e        state, state_nxt;
    logic [SEL_W-1:0] target, target_nxt, active_nxt;
    logic             req_other_c, retarget_c, quiet_c, tmr_clear_c, tmr_done_c;

    // Out-of-range requests behave as a request for the current source.
    assign req_other_c = (32'(sel_req) < NUM_SRC) && (sel_req != active_sel);
    assign retarget_c  = (sel_req != target);
    assign quiet_c     = tx_in[active_sel] & tx_in[target];
    assign tmr_clear_c = (state != PENDING) || !quiet_c || retarget_c;

    line_idle_timer #(
        .WINDOW (WINDOW)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear_c),
        .enable  (quiet_c),
        .done_c  (tmr_done_c)
    );

    // Next-state and select bookkeeping.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        active_nxt = active_sel;
        unique case (state)
            LOCKED: begin
                if (req_other_c) begin
                    state_nxt  = PENDING;
                    target_nxt = sel_req;
                end
            end
            PENDING: begin
                if (!req_other_c) begin
                    state_nxt = LOCKED;
                end else if (retarget_c) begin
                    target_nxt = sel_req;
                end else if (force_switch || tmr_done_c) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                active_nxt = target;
                state_nxt  = LOCKED;
            end
            default: state_nxt = LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= LOCKED;
            target         <= SEL_W'(RESET_SEL);
            active_sel     <= SEL_W'(RESET_SEL);
            TXD            <= 1'b1;
            switch_pending <= 1'b0;
            switch_done    <= 1'b0;
        end else begin
            state          <= state_nxt;
            target         <= target_nxt;
            active_sel     <= active_nxt;
            TXD            <= tx_in[active_sel];
            switch_pending <= (state_nxt == PENDING);
            switch_done    <= (state_nxt == COMMIT);
        end
    end

endmodule

// File: tb/tb_uart_tx_switch.sv
// Directed bench for uart_tx_switch with a TXD scoreboard queue (NUM_SRC=5, W=12).
module tb_uart_tx_switch;

    localparam int unsigned NSRC = 5;
    localparam int unsigned BAUD = 4;
    localparam int unsigned IDLE = 3;
    localparam int unsigned SW   = 3;

    logic            clk;
    logic            reset_n;
    logic [NSRC-1:0] tx_in;
    logic [SW-1:0]   sel_req;
    logic            force_switch;
    logic            TXD;
    logic [SW-1:0]   active_sel;
    logic            switch_pending;
    logic            switch_done;

    int       n_chk;
    int       n_fail;
    int       done_cnt;
    int       done_base;
    logic [SW-1:0] exp_active;
    logic     exp_q[$];

    uart_tx_switch #(
        .NUM_SRC     (NSRC),
        .BAUD_PERIOD (BAUD),
        .IDLE_BITS   (IDLE),
        .RESET_SEL   (0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tx_in          (tx_in),
        .sel_req        (sel_req),
        .force_switch   (force_switch),
        .TXD            (TXD),
        .active_sel     (active_sel),
        .switch_pending (switch_pending),
        .switch_done    (switch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: queue the TXD value owed next cycle, then score what arrived.
    task automatic tick();
        logic e;
        exp_q.push_back(tx_in[exp_active]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("txd", 32'(TXD), 32'(e));
        if (switch_done) done_cnt++;
    endtask

    task automatic send_frame(input int src, input logic [7:0] data);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      tx_in[src] = 1'b0;
            else if (k == 9) tx_in[src] = 1'b1;
            else             tx_in[src] = data[k-1];
            repeat (BAUD) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; done_cnt = 0;
        reset_n = 1'b0; tx_in = '1; sel_req = '0; force_switch = 1'b0; exp_active = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd", 32'(TXD), 32'd1);
        chk("rst_active", 32'(active_sel), 32'd0);
        chk("rst_pending", 32'(switch_pending), 32'd0);
        chk("rst_done", 32'(switch_done), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Idle lines, 0 -> 1: pending at t+1, done at t+13, active at t+14.
        sel_req = 3'd1;
        tick();
        chk("s1_pending", 32'(switch_pending), 32'd1);
        chk("s1_done_early", 32'(switch_done), 32'd0);
        repeat (11) tick();
        chk("s1_done_t12", 32'(switch_done), 32'd0);
        chk("s1_pending_t12", 32'(switch_pending), 32'd1);
        tick();
        chk("s1_done_t13", 32'(switch_done), 32'd1);
        chk("s1_active_t13", 32'(active_sel), 32'd0);
        tick();
        chk("s1_active_t14", 32'(active_sel), 32'd1);
        chk("s1_done_t14", 32'(switch_done), 32'd0);
        exp_active = 3'd1;
        tx_in[1] = 1'b0;
        tick();
        chk("s1_txd_t15", 32'(TXD), 32'd0);
        tx_in[1] = 1'b1;
        tick();

        // Frame on the active line holds off the switch until 12 quiet cycles after stop.
        done_base = done_cnt;
        sel_req = 3'd0;
        tick();
        chk("s2_pending", 32'(switch_pending), 32'd1);
        send_frame(1, 8'h55);
        chk("s2_pending_after_frame", 32'(switch_pending), 32'd1);
        chk("s2_no_done_in_frame", 32'(done_cnt - done_base), 32'd0);
        repeat (7) tick();
        chk("s2_done_stop11", 32'(switch_done), 32'd0);
        tick();
        chk("s2_done_stop12", 32'(switch_done), 32'd1);
        tick();
        chk("s2_active", 32'(active_sel), 32'd0);
        exp_active = 3'd0;

        // Retarget 2 -> 3 restarts the window; exactly one switch.
        done_base = done_cnt;
        sel_req = 3'd2;
        repeat (5) tick();
        chk("s3_pending", 32'(switch_pending), 32'd1);
        sel_req = 3'd3;
        repeat (12) tick();
        chk("s3_done_early", 32'(switch_done), 32'd0);
        tick();
        chk("s3_done", 32'(switch_done), 32'd1);
        tick();
        chk("s3_active", 32'(active_sel), 32'd3);
        exp_active = 3'd3;
        repeat (3) tick();
        chk("s3_single_pulse", 32'(done_cnt - done_base), 32'd1);

        // Withdrawn request drops; invalid selects never pend.
        done_base = done_cnt;
        sel_req = 3'd1;
        repeat (6) tick();
        chk("s4_pending", 32'(switch_pending), 32'd1);
        sel_req = 3'd3;
        tick();
        chk("s4_withdrawn", 32'(switch_pending), 32'd0);
        repeat (15) tick();
        sel_req = 3'd5;
        repeat (2) tick();
        chk("s4_invalid5_pending", 32'(switch_pending), 32'd0);
        sel_req = 3'd7;
        repeat (15) tick();
        chk("s4_invalid7_pending", 32'(switch_pending), 32'd0);
        chk("s4_active", 32'(active_sel), 32'd3);
        chk("s4_no_done", 32'(done_cnt - done_base), 32'd0);
        sel_req = 3'd3;
        tick();

        // Force mid-frame: active changes two cycles after the pulse.
        sel_req = 3'd4;
        tick();
        tx_in[3] = 1'b0;
        repeat (2) tick();
        force_switch = 1'b1;
        tick();
        force_switch = 1'b0;
        chk("s5_done", 32'(switch_done), 32'd1);
        chk("s5_active_p1", 32'(active_sel), 32'd3);
        tick();
        chk("s5_active_p2", 32'(active_sel), 32'd4);
        exp_active = 3'd4;
        tx_in[3] = 1'b1;
        tick();

        // Force while locked is ignored.
        done_base = done_cnt;
        force_switch = 1'b1;
        tick();
        force_switch = 1'b0;
        repeat (2) tick();
        chk("s5_locked_force", 32'(done_cnt - done_base), 32'd0);
        chk("s5_locked_active", 32'(active_sel), 32'd4);

        // Async reset during PENDING restores RESET_SEL and idle TXD at once.
        sel_req = 3'd2;
        tx_in[4] = 1'b0;
        repeat (3) tick();
        chk("s6_pending", 32'(switch_pending), 32'd1);
        chk("s6_txd_low", 32'(TXD), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_txd", 32'(TXD), 32'd1);
        chk("s6_rst_active", 32'(active_sel), 32'd0);
        chk("s6_rst_pending", 32'(switch_pending), 32'd0);
        exp_q.delete();
        @(posedge clk);
        sel_req = 3'd0;
        tx_in = '1;
        exp_active = 3'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        done_base = done_cnt;
        repeat (15) tick();
        chk("s6_after_active", 32'(active_sel), 32'd0);
        chk("s6_after_pending", 32'(switch_pending), 32'd0);
        chk("s6_after_done", 32'(done_cnt - done_base), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
